// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial-to-parallel word assembler with valid/ready output and sticky overflow
module shift_deserializer #(
    parameter int BW_DATA   = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_s,
    input  logic                       i_s_vld,
    input  logic                       i_clr,
    input  logic                       i_rdy,
    output logic [BW_DATA-1:0]         o_q,
    output logic                       o_vld,
    output logic                       o_ovf,
    output logic [$clog2(BW_DATA)-1:0] o_bit_cnt
);

    localparam int CW = $clog2(BW_DATA);
    localparam logic [CW-1:0] LAST_CNT = CW'(BW_DATA - 1);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BW_DATA-1:0] r_sh;
    logic [BW_DATA-1:0] w_sh_nxt;
    logic [CW-1:0]      r_cnt;
    logic [BW_DATA-1:0] r_q;
    logic               r_ovf;
    logic               w_shift;
    logic               w_done;
    logic               w_load;
    logic               w_ovf_set;

    // i_clr takes priority over a valid bit, so a cleared cycle never completes a word
    assign w_shift = i_s_vld & ~i_clr;
    assign w_done  = w_shift & (r_cnt == LAST_CNT);

    always_comb begin
        w_sh_nxt = r_sh;
        if (MSB_FIRST) begin
            w_sh_nxt = {r_sh[BW_DATA-2:0], i_s};
        end else begin
            w_sh_nxt = {i_s, r_sh[BW_DATA-1:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_s_vld) begin
            r_sh  <= w_sh_nxt;
            r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_done) begin
                    w_state_nxt = S_FULL;
                    w_load      = 1'b1;
                end
            end
            S_FULL: begin
                if (w_done && i_rdy) begin
                    w_load = 1'b1;
                end else if (w_done) begin
                    w_ovf_set = 1'b1;
                end else if (i_rdy) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // the completed word is taken from w_sh_nxt so it includes the bit sampled this edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_EMPTY;
            r_q     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_q <= w_sh_nxt;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_q       = r_q;
    assign o_vld     = (r_state == S_FULL);
    assign o_ovf     = r_ovf;
    assign o_bit_cnt = r_cnt;

endmodule
